// File: rtl/axi4_wr_chan_fifo.sv
// AXI4 write-channel buffer: independent AW, W and B FIFOs with an
// outstanding-burst limiter and optional store-and-forward release of bursts.

// Synchronous FIFO with extra-MSB pointers. No bypass: a pushed entry
// appears at dout on the cycle after the push.
module axi4_wr_chan_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[PW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; emptiness is defined by the pointers, so
  // clearing storage would only cost logic and block RAM inference.
  always_ff @(posedge aclk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= din;
  end
endmodule

module axi4_wr_chan_fifo #(
  parameter int AW_W        = 64,
  parameter int W_W         = 73,
  parameter int B_W         = 6,
  parameter int AW_DEPTH    = 4,
  parameter int W_DEPTH     = 256,
  parameter int B_DEPTH     = 4,
  parameter int MAX_OUT     = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [7:0]                    s_awlen,
  input  logic [AW_W-1:0]               s_aw_payload,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  input  logic                          s_wlast,
  input  logic [W_W-1:0]                s_w_payload,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  output logic [B_W-1:0]                s_b_payload,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [7:0]                    m_awlen,
  output logic [AW_W-1:0]               m_aw_payload,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic                          m_wlast,
  output logic [W_W-1:0]                m_w_payload,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  input  logic [B_W-1:0]                m_b_payload,
  output logic [$clog2(AW_DEPTH):0]     aw_count,
  output logic [$clog2(W_DEPTH):0]      w_count,
  output logic [$clog2(B_DEPTH):0]      b_count,
  output logic [$clog2(MAX_OUT):0]      outstanding
);
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  // bursts_ready + w_credit equals the number of wlast beats held in the
  // W FIFO, so sizing both for W_DEPTH rules out overflow (and covers AW_DEPTH).
  localparam int CR_W  = $clog2(W_DEPTH) + 1;

  if (PACKET_MODE != 0 && W_DEPTH < 256) begin : g_bad_w_depth
    $error("axi4_wr_chan_fifo: store-and-forward needs W_DEPTH >= 256 to hold a full burst");
  end
  if (MAX_OUT < 1 || MAX_OUT > B_DEPTH) begin : g_bad_max_out
    $error("axi4_wr_chan_fifo: MAX_OUT must lie in 1..B_DEPTH");
  end

  logic aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
  logic s_aw_hs, s_w_hs, m_aw_hs, m_w_hs, m_b_hs, s_b_hs;
  logic [CR_W-1:0] bursts_ready;
  logic [CR_W-1:0] w_credit;
  logic [OUT_W-1:0] out_cnt;

  assign s_awready = !aw_full;
  assign s_wready  = !w_full;
  assign m_bready  = !b_full;
  assign s_bvalid  = !b_empty;

  assign m_awvalid = !aw_empty && (out_cnt < OUT_W'(MAX_OUT)) &&
                     ((PACKET_MODE == 0) || (bursts_ready != '0));
  assign m_wvalid  = !w_empty && ((PACKET_MODE == 0) || (w_credit != '0));

  assign s_aw_hs = s_awvalid && s_awready;
  assign s_w_hs  = s_wvalid  && s_wready;
  assign m_aw_hs = m_awvalid && m_awready;
  assign m_w_hs  = m_wvalid  && m_wready;
  assign m_b_hs  = m_bvalid  && m_bready;
  assign s_b_hs  = s_bvalid  && s_bready;

  assign outstanding = out_cnt;

  axi4_wr_chan_fifo_sync #(.WIDTH(AW_W + 8), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .aclk(aclk), .areset(areset),
    .push(s_aw_hs), .din({s_awlen, s_aw_payload}),
    .pop(m_aw_hs), .dout({m_awlen, m_aw_payload}),
    .full(aw_full), .empty(aw_empty), .count(aw_count)
  );

  axi4_wr_chan_fifo_sync #(.WIDTH(W_W + 1), .DEPTH(W_DEPTH)) u_w_fifo (
    .aclk(aclk), .areset(areset),
    .push(s_w_hs), .din({s_wlast, s_w_payload}),
    .pop(m_w_hs), .dout({m_wlast, m_w_payload}),
    .full(w_full), .empty(w_empty), .count(w_count)
  );

  axi4_wr_chan_fifo_sync #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .aclk(aclk), .areset(areset),
    .push(m_b_hs), .din(m_b_payload),
    .pop(s_b_hs), .dout(s_b_payload),
    .full(b_full), .empty(b_empty), .count(b_count)
  );

  // Outstanding bursts: issued on m_aw, retired on m_b; both at once cancel.
  // NOTE: state registers use non-blocking assignment so every block sees
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge aclk) begin
    if (areset)                 out_cnt <= '0;
    else if (m_aw_hs && !m_b_hs) out_cnt <= out_cnt + 1'b1;
    else if (m_b_hs && !m_aw_hs) out_cnt <= out_cnt - 1'b1;
  end

  // Completed W bursts still waiting for their AW to be released.
  always_ff @(posedge aclk) begin
    if (areset)                                 bursts_ready <= '0;
    else if ((s_w_hs && s_wlast) && !m_aw_hs)   bursts_ready <= bursts_ready + 1'b1;
    else if (m_aw_hs && !(s_w_hs && s_wlast))   bursts_ready <= bursts_ready - 1'b1;
  end

  // Bursts whose AW has gone out and whose W beats may now drain.
  always_ff @(posedge aclk) begin
    if (areset)                                 w_credit <= '0;
    else if (m_aw_hs && !(m_w_hs && m_wlast))   w_credit <= w_credit + 1'b1;
    else if ((m_w_hs && m_wlast) && !m_aw_hs)   w_credit <= w_credit - 1'b1;
  end
endmodule

// File: doc/axi4_wr_chan_fifo.md
AXI4_WR_CHAN_FIFO -- requirements
Module: axi4_wr_chan_fifo

Interface
REQ-001 SHALL have parameters (name, default, meaning): AW_W 64 AW payload bits excluding awlen; W_W 73 W payload bits excluding wlast; B_W 6 B payload bits; AW_DEPTH 4, W_DEPTH 256, B_DEPTH 4 entries, each a power of 2 and >=2; MAX_OUT 4 outstanding bursts, 1..B_DEPTH; PACKET_MODE 0 (0 cut-through, 1 store-and-forward).
REQ-002 SHALL have ports (name direction width meaning): aclk in 1 clock; areset in 1 sync active-high reset.
REQ-003 SHALL have ports s_awvalid in 1, s_awready out 1, s_awlen in 8, s_aw_payload in AW_W: upstream AW.
REQ-004 SHALL have ports s_wvalid in 1, s_wready out 1, s_wlast in 1, s_w_payload in W_W: upstream W.
REQ-005 SHALL have ports s_bvalid out 1, s_bready in 1, s_b_payload out B_W: upstream B.
REQ-006 SHALL have ports m_awvalid out 1, m_awready in 1, m_awlen out 8, m_aw_payload out AW_W: downstream AW.
REQ-007 SHALL have ports m_wvalid out 1, m_wready in 1, m_wlast out 1, m_w_payload out W_W: downstream W.
REQ-008 SHALL have ports m_bvalid in 1, m_bready out 1, m_b_payload in B_W: downstream B.
REQ-009 SHALL have ports aw_count, w_count, b_count out clog2(depth)+1 each: FIFO occupancy; outstanding out clog2(MAX_OUT)+1: bursts issued without B.
REQ-010 SHALL use one clock aclk; reset areset is synchronous and active-high.

Function
REQ-011 SHALL contain three independent synchronous FIFOs: AW {awlen,payload}, W {wlast,payload}, B {payload}.
REQ-012 SHALL transfer on any channel only in a cycle where valid and ready are both high.
REQ-013 SHALL drive s_awready=!aw_full, s_wready=!w_full, m_bready=!b_full, combinationally from registered state only.
REQ-014 SHALL make an accepted entry visible at FIFO output on the next cycle; no same-cycle bypass when empty.
REQ-015 SHALL, on simultaneous push and pop with FIFO neither empty nor full, keep count unchanged; with FIFO full, push is blocked by ready low.
REQ-016 SHALL wrap read/write pointers modulo depth with an extra MSB distinguishing full from empty.
REQ-017 SHALL hold output valid asserted and payload stable until accepted (no retraction).
REQ-018 SHALL maintain outstanding: +1 on m_aw handshake, -1 on m_b handshake, unchanged when both occur same cycle.
REQ-019 SHALL gate m_awvalid low whenever outstanding==MAX_OUT.
REQ-020 SHALL, with PACKET_MODE=0, drive m_awvalid=!aw_empty&&outstanding<MAX_OUT and m_wvalid=!w_empty.
REQ-021 SHALL, with PACKET_MODE=1, keep bursts_ready counter: +1 on s_w handshake with s_wlast, -1 on m_aw handshake; m_awvalid additionally requires bursts_ready>0.
REQ-022 SHALL, with PACKET_MODE=1, keep w_credit counter: +1 on m_aw handshake, -1 on m_w handshake with m_wlast; m_wvalid requires !w_empty&&w_credit>0.
REQ-023 SHALL size bursts_ready and w_credit to hold AW_DEPTH without overflow; simultaneous +1/-1 leaves them unchanged.
REQ-024 SHALL, with PACKET_MODE=1, require W_DEPTH>=256 (elaboration-time assertion fails otherwise).
REQ-025 SHALL NOT check awlen against beat count; mismatch is an upstream protocol error, behaviour unspecified beyond no X propagation.
REQ-026 SHALL pass s_bvalid=!b_empty with B payload in arrival order.

Reset
REQ-027 SHALL, while areset high at a clock edge, clear all pointers and counters; next cycle: all *valid outputs 0, all counts 0, outstanding 0, s_awready/s_wready/m_bready 1.
REQ-028 SHALL discard all buffered entries on reset mid-operation; payload outputs are don't-care while valid low.

Verification
REQ-029 Cut-through: AW len=3 then 4 W beats, m ready=1 -> m_awvalid 1 cycle after s_aw handshake, 4 beats out in order, wlast on 4th.
REQ-030 Packet mode: AW len=7, 7 W beats -> m_awvalid stays 0; 8th beat with wlast -> m_awvalid 1 next cycle, then 8 W beats released.
REQ-031 Outstanding limit MAX_OUT=4, m_bvalid=0: 5 single-beat bursts -> 4 m_aw handshakes, 5th held, outstanding=4; one m_b handshake -> 5th issues, outstanding stays 4.
REQ-032 Full: m_wready=0, push W_DEPTH beats -> w_count=W_DEPTH, s_wready=0; one pop -> s_wready=1 next cycle; concurrent push/pop keeps count.
REQ-033 Reset mid-burst: assert areset with aw_count=2, w_count=5 -> next cycle all counts 0, m_awvalid=m_wvalid=s_bvalid=0.
REQ-034 Random stall: random valid/ready on all six ports, 10k bursts -> scoreboard order and payload match, no overflow, no valid retraction.
